subbytes_iter: RTL and testbench
================================

# subbytes_iter

Iterative forward AES SubBytes engine: accepts a 128-bit state through a valid/ready handshake and substitutes it through `BYTES_PER_CYCLE` shared forward S-box instances. The result is presented on a registered valid/ready output. It is the encrypt-direction counterpart of the inverse SubBytes stage, for area-constrained round datapaths where 16 parallel S-boxes are too costly. It instantiates the codebase's forward `sbox` module (8-bit in, 8-bit out, combinational).

## Interface
- `BYTES_PER_CYCLE`, default 4: bytes substituted per busy cycle.
  - Legal values: 1, 2, 4, 8, 16.
  - Any other value is an elaboration error.
  - Derived: `N = 16 / BYTES_PER_CYCLE` busy cycles per block.
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: block can accept a state (high only in IDLE).
- `in_data`, input, 128: input state. Byte 0 is `[127:120]` and byte 15 is `[7:0]`.
- `out_valid`, output, 1: `out_data` holds a complete substituted state.
- `out_ready`, input, 1: downstream accepts `out_data`.
- `out_data`, output, 128: substituted state, same byte ordering as `in_data`.
- `busy`, output, 1: high while in BUSY.

## Operation
- Internal 128-bit work register `st` and a 4-bit chunk counter `cnt`.
- FSM states:
  - **IDLE**
    - Drives `in_ready=1`.
    - On `in_valid && in_ready`: `st <= in_data`, `cnt <= 0`, go to BUSY.
  - **BUSY**
    - Each cycle, bytes `cnt*BPC .. cnt*BPC+BPC-1` of `st` (counting from byte 0 at the MSB end) are replaced by `sbox(byte)`. All other bytes are held.
    - `cnt` increments each cycle.
    - When `cnt == N-1`, that chunk is written and the FSM goes to DONE.
    - `in_valid` is ignored.
  - **DONE**
    - Drives `out_valid=1`, with `out_data = st` held stable.
    - On `out_ready`, go to IDLE.
    - `in_ready=0` for the whole of DONE, so there is no overlap with the next input.
- Output decode:
  - `in_ready = (state==IDLE)`.
  - `out_valid = (state==DONE)`.
  - `busy = (state==BUSY)`.
  - `out_data = st` at all times; the value is meaningful only when `out_valid=1`.
- Width rules:
  - `cnt` counts 0..N-1 and never wraps past N-1.
  - With `BPC=16`, BUSY lasts exactly one cycle.
- Upstream may change `in_data` freely when not handshaking. `st` is captured only on the accept edge.
- Downstream may hold `out_ready` low indefinitely. `out_data` and `out_valid` must remain stable until the handshake.

## Timing
- Reset (asynchronous, on `rst_n` low, independent of `clk`):
  - state goes to IDLE, `cnt=0`, `st=0`.
  - Outputs during and after reset: `in_ready=1`, `out_valid=0`, `busy=0`, `out_data=0`.
- Reset asserted in BUSY or DONE aborts the block. No `out_valid` is produced for it.
- Latency, with the accept edge as E0:
  - Busy edges are E1..EN.
  - `out_valid` is high in the cycle after EN, i.e. N cycles after acceptance.
  - Default `BPC=4`: 4 cycles.
- The output handshake occurs on the first edge in DONE with `out_ready=1`. `in_ready` is high in the following cycle.
- Minimum initiation interval is N+2 cycles. This applies with `in_valid` and `out_ready` held high.
- `in_valid` and `out_ready` need no protocol relationship. `out_ready` high before DONE has no effect.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.

## Test plan
- **Reset values:** assert `rst_n=0` mid-cycle with no clock edge.
  - Expect `in_ready=1`, `out_valid=0`, `busy=0`, `out_data=0` immediately.
- **FIPS-197 vector, `BPC=4`:** drive `in_data=193de3bea0f4e22b9ac68d2ae9f84808` with `out_ready=1`.
  - Expect `out_data=d42711aee0bf98f1b8b45de51e415230` with `out_valid` exactly 4 cycles after accept.
  - Expect `busy` high for 4 cycles.
- **All `BPC` values (1, 2, 4, 8, 16):**
  - Input all-zero: expect `6363…63`, with latency 16/8/4/2/1 cycles respectively.
  - Input all-`ff`: expect `1616…16`.
- **Backpressure:** hold `out_ready=0` for 10 cycles after `out_valid`.
  - Expect `out_data` stable and `in_ready=0` throughout.
  - Expect `in_valid` pulses with new data to be ignored.
  - On release, expect one handshake, then `in_ready=1` the next cycle.
- **Back-to-back:** stream 100 random states with `in_valid=out_ready=1`.
  - Each output must equal per-byte `sbox` of its input, in order.
  - Initiation interval must be exactly N+2.
  - Feeding each output through the inverse SubBytes block must return the original input.
- **Reset mid-operation:** pulse `rst_n` low during the second BUSY cycle.
  - Expect immediate return to IDLE and no `out_valid` for the aborted block.
  - The next accepted block must produce the correct result.

Source files
------------

// File: rtl/subbytes_iter_if.sv
// Valid/ready handshake bundle for the iterative forward SubBytes engine.
// The master side feeds states and drains results; the slave side is the engine.
interface subbytes_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/subbytes_iter.sv
// Iterative forward AES SubBytes: substitutes a 128-bit state BYTES_PER_CYCLE bytes per cycle
// through shared forward S-boxes, holding the result until the downstream handshake.
module sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'd0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'd1;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) begin
                r = gf_mul(r, x);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    logic [7:0] inv_s;

    // Inversion followed by the AES affine transform.
    always_comb begin
        inv_s = gf_inv(din);
        dout  = inv_s ^ {inv_s[6:0], inv_s[7]} ^ {inv_s[5:0], inv_s[7:6]}
                      ^ {inv_s[4:0], inv_s[7:5]} ^ {inv_s[3:0], inv_s[7:4]} ^ 8'h63;
    end
endmodule

module subbytes_iter #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    subbytes_iter_if.slave bus
);
    localparam int N = 16 / BYTES_PER_CYCLE;

    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bpc_check
        $error("subbytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_r;
    state_t       state_s;
    logic [3:0]   cnt_r;
    logic [3:0]   cnt_s;
    logic [127:0] st_r;
    logic [127:0] st_s;
    logic [127:0] st_busy_s;
    logic [7:0]   sb_in_s  [BYTES_PER_CYCLE];
    logic [7:0]   sb_out_s [BYTES_PER_CYCLE];

    // Byte 0 sits at the MSB end, so chunk byte j of counter c lives at 8*(15-idx).
    function automatic logic [6:0] byte_lsb(input logic [3:0] c, input int j);
        int idx;
        idx = int'(c) * BYTES_PER_CYCLE + j;
        return 7'(8 * (15 - idx));
    endfunction

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
        sbox u_sbox (.din(sb_in_s[g]), .dout(sb_out_s[g]));
    end

    // Route the bytes addressed by the chunk counter into the shared S-boxes.
    always_comb begin
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            sb_in_s[j] = st_r[byte_lsb(cnt_r, j) +: 8];
        end
    end

    // Merge the substituted chunk back into the work register image.
    always_comb begin
        st_busy_s = st_r;
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            st_busy_s[byte_lsb(cnt_r, j) +: 8] = sb_out_s[j];
        end
    end

    // Next-state, counter and work-register update.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        st_s    = st_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    st_s    = bus.in_data;
                    cnt_s   = 4'd0;
                    state_s = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                st_s = st_busy_s;
                // The counter parks on the last chunk rather than wrapping.
                if (cnt_r == 4'(N - 1)) begin
                    state_s = DONE;
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
                st_s    = 128'd0;
            end
        endcase
    end

    // State, counter and work register with asynchronous abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            st_r    <= 128'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            st_r    <= st_s;
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.busy      = (state_r == BUSY);
    assign bus.out_data  = st_r;
endmodule

// File: tb/tb_subbytes_iter.sv
// Directed bench for subbytes_iter: reset, FIPS-197 vector, all chunk widths,
// backpressure, back-to-back streaming and reset abort.
module tb_subbytes_iter;
    localparam logic [2047:0] SBOX_ROM = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_data;
    logic [7:0]   inv_tab [256];
    int           n_tests;
    int           n_fail;

    subbytes_iter_if b1 ();
    subbytes_iter_if b2 ();
    subbytes_iter_if b4 ();
    subbytes_iter_if b8 ();
    subbytes_iter_if b16 ();

    subbytes_iter #(.BYTES_PER_CYCLE(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(b1));
    subbytes_iter #(.BYTES_PER_CYCLE(2))  u2  (.clk(clk), .rst_n(rst_n), .bus(b2));
    subbytes_iter #(.BYTES_PER_CYCLE(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(b4));
    subbytes_iter #(.BYTES_PER_CYCLE(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    subbytes_iter #(.BYTES_PER_CYCLE(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));

    assign b1.in_valid  = in_valid;  assign b1.in_data  = in_data;  assign b1.out_ready  = out_ready;
    assign b2.in_valid  = in_valid;  assign b2.in_data  = in_data;  assign b2.out_ready  = out_ready;
    assign b4.in_valid  = in_valid;  assign b4.in_data  = in_data;  assign b4.out_ready  = out_ready;
    assign b8.in_valid  = in_valid;  assign b8.in_data  = in_data;  assign b8.out_ready  = out_ready;
    assign b16.in_valid = in_valid;  assign b16.in_data = in_data;  assign b16.out_ready = out_ready;

    logic         ov [5];
    logic [127:0] od [5];
    assign ov[0] = b1.out_valid;  assign od[0] = b1.out_data;
    assign ov[1] = b2.out_valid;  assign od[1] = b2.out_data;
    assign ov[2] = b4.out_valid;  assign od[2] = b4.out_data;
    assign ov[3] = b8.out_valid;  assign od[3] = b8.out_data;
    assign ov[4] = b16.out_valid; assign od[4] = b16.out_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] fsb(input logic [7:0] b);
        return SBOX_ROM[8 * (255 - int'(b)) +: 8];
    endfunction

    function automatic logic [127:0] fsub(input logic [127:0] x);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = fsb(x[8*k +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] isub(input logic [127:0] x);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_tab[x[8*k +: 8]];
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    // Send one block into the BPC=4 instance; latency counts edges after the accept edge.
    task automatic run4(input logic [127:0] din, output logic [127:0] dout,
                        output int lat, output int nbusy);
        @(negedge clk);
        in_data  = din;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat   = -1;
        nbusy = 0;
        dout  = 128'd0;
        for (int k = 1; k <= 30; k++) begin
            if (b4.busy) nbusy++;
            if (b4.out_valid) begin
                lat  = k - 1;
                dout = b4.out_data;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic bpc_sweep(input string name, input logic [127:0] din, input logic [127:0] exp);
        int           lat [5];
        logic [127:0] got [5];
        int           exp_lat [5] = '{16, 8, 4, 2, 1};
        for (int d = 0; d < 5; d++) begin
            lat[d] = 0;
            got[d] = 128'd0;
        end
        @(negedge clk);
        in_data  = din;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            for (int d = 0; d < 5; d++) begin
                if (ov[d] && lat[d] == 0) begin
                    lat[d] = k - 1;
                    got[d] = od[d];
                end
            end
            @(negedge clk);
        end
        for (int d = 0; d < 5; d++) begin
            check($sformatf("%s_lat_bpc%0d", name, 16 / exp_lat[d]), 128'(lat[d]), 128'(exp_lat[d]));
            check($sformatf("%s_data_bpc%0d", name, 16 / exp_lat[d]), got[d], exp);
        end
    endtask

    initial begin
        logic [127:0] dout;
        logic [127:0] q_exp [$];
        logic [127:0] q_src [$];
        logic [127:0] src;
        int           lat;
        int           nbusy;
        int           sent;
        int           rcvd;
        int           last_acc;
        int           nvalid;

        n_tests   = 0;
        n_fail    = 0;
        in_valid  = 1'b0;
        in_data   = 128'd0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        for (int i = 0; i < 256; i++) inv_tab[fsb(8'(i))] = 8'(i);

        // Asynchronous reset mid-cycle, no clock edge involved.
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready",  128'(b4.in_ready),  128'd1);
        check("rst_out_valid", 128'(b4.out_valid), 128'd0);
        check("rst_busy",      128'(b4.busy),      128'd0);
        check("rst_out_data",  b4.out_data,        128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        bpc_sweep("zero", 128'd0, {16{8'h63}});
        bpc_sweep("ones", {16{8'hff}}, {16{8'h16}});
        drain();

        // FIPS-197 SubBytes example.
        run4(128'h193de3bea0f4e22b9ac68d2ae9f84808, dout, lat, nbusy);
        check("fips_data",  dout, 128'hd42711aee0bf98f1b8b45de51e415230);
        check("fips_lat",   128'(lat),   128'd4);
        check("fips_busy",  128'(nbusy), 128'd4);
        @(negedge clk);
        check("fips_ready_after", 128'(b4.in_ready),  128'd1);
        check("fips_valid_after", 128'(b4.out_valid), 128'd0);
        drain();

        // Backpressure: result must hold while new inputs are ignored.
        out_ready = 1'b0;
        run4(128'h00112233445566778899aabbccddeeff, dout, lat, nbusy);
        check("bp_data", dout, 128'h638293c31bfc33f5c4eeacea4bc12816);
        for (int k = 0; k < 10; k++) begin
            check("bp_hold_valid", 128'(b4.out_valid), 128'd1);
            check("bp_hold_ready", 128'(b4.in_ready),  128'd0);
            check("bp_hold_data",  b4.out_data, 128'h638293c31bfc33f5c4eeacea4bc12816);
            in_valid = k[0];
            in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 128'(b4.out_valid), 128'd0);
        check("bp_release_ready", 128'(b4.in_ready),  128'd1);
        drain();

        // Back-to-back stream of random states.
        sent     = 0;
        rcvd     = 0;
        last_acc = -1;
        for (int c = 0; c < 1000 && rcvd < 100; c++) begin
            if (b4.out_valid) begin
                check("b2b_queue", 128'(q_exp.size() > 0), 128'd1);
                if (q_exp.size() > 0) begin
                    src = q_src.pop_front();
                    check("b2b_data", b4.out_data, q_exp.pop_front());
                    check("b2b_inverse", isub(b4.out_data), src);
                end
                rcvd++;
            end
            if (b4.in_ready) begin
                if (sent < 100) begin
                    in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
                    in_valid = 1'b1;
                    q_src.push_back(in_data);
                    q_exp.push_back(fsub(in_data));
                    if (last_acc >= 0) check("b2b_ii", 128'(c - last_acc), 128'd6);
                    last_acc = c;
                    sent++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("b2b_count", 128'(rcvd), 128'd100);
        drain();

        // Reset during the second busy cycle aborts the block.
        @(negedge clk);
        in_data  = 128'h0123456789abcdeffedcba9876543210;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("abort_busy_before", 128'(b4.busy), 128'd1);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready",  128'(b4.in_ready),  128'd1);
        check("abort_busy",      128'(b4.busy),      128'd0);
        check("abort_out_valid", 128'(b4.out_valid), 128'd0);
        check("abort_out_data",  b4.out_data,        128'd0);
        #1 rst_n = 1'b1;
        nvalid = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (b4.out_valid) nvalid++;
        end
        check("abort_no_valid", 128'(nvalid), 128'd0);
        run4(128'h00112233445566778899aabbccddeeff, dout, lat, nbusy);
        check("post_abort_data", dout, 128'h638293c31bfc33f5c4eeacea4bc12816);
        check("post_abort_lat",  128'(lat), 128'd4);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
